// File: rtl/quant_stage.sv
// quant_stage: JPEG quantization stage.
// Takes signed DCT coefficients in natural order, one per accepted beat. Each one is
// multiplied by the per-position reciprocal round(2^SHIFT/Q) held in a 64-entry table
// that software writes. The result is shifted right, saturated to OW bits and emitted
// on a valid/ready stream tagged with the coefficient index.
// Optional build macro: QUANT_ROUND_EN selects round half away from zero.
// When it is undefined the stage truncates toward zero.
// Both modes are sign-symmetric.
module quant_stage #(
  parameter int IW    = 16,
  parameter int RW    = 16,
  parameter int SHIFT = 14,
  parameter int OW    = 12
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 tab_we_i,
  input  logic [5:0]           tab_addr_i,
  input  logic [RW-1:0]        tab_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [IW-1:0] in_data_i,
  input  logic                 in_first_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic signed [OW-1:0] out_data_o,
  output logic [5:0]           out_idx_o,
  output logic                 out_last_o,
  output logic [15:0]          blk_cnt_o,
  output logic                 sync_err_o
);

  // The product is wide enough for |x| up to 2^(IW-1) times a full-scale reciprocal.
  // It also has one spare bit so the rounding constant cannot overflow.
  localparam int PW = IW + RW + 1;
  localparam int QW = PW - SHIFT;

  localparam logic [QW-1:0] POS_LIM = QW'(2 ** (OW - 1) - 1);
  localparam logic [QW-1:0] NEG_LIM = QW'(2 ** (OW - 1));
  localparam logic [OW-1:0] POS_MAG = OW'(2 ** (OW - 1) - 1);
  localparam logic [OW-1:0] NEG_MAG = OW'(2 ** (OW - 1));

`ifdef QUANT_ROUND_EN
  localparam logic [PW-1:0] RND_HALF = PW'(2 ** (SHIFT - 1));
`endif

  logic [RW-1:0] tab_mem [64];

  logic       stall;
  logic       accept;
  logic [5:0] idx_cnt;
  logic [5:0] cur_idx;

  logic                 s1_valid;
  logic signed [IW-1:0] s1_data;
  logic [5:0]           s1_idx;
  logic [RW-1:0]        s1_rec;
  logic [IW:0]          s1_ext;
  logic [IW:0]          s1_mag;
  logic [PW-1:0]        s1_prod;

  logic          s2_valid;
  logic          s2_neg;
  logic [5:0]    s2_idx;
  logic [PW-1:0] s2_prod;
  logic [QW-1:0] s2_q;
  logic [OW-1:0] s2_sat;
  logic [OW-1:0] s2_res;

  // A full output register that is not being taken freezes the whole pipe.
  assign stall      = out_valid_o && !out_ready_i;
  assign in_ready_o = !stall;
  assign accept     = in_valid_i && in_ready_o;

  // in_first_i always wins, so a misaligned producer is pulled back onto index 0.
  assign cur_idx = in_first_i ? 6'd0 : idx_cnt;

  // The reciprocal table is not reset; software loads it before streaming.
  always_ff @(posedge wb_clk_i) begin
    if (tab_we_i) begin
      tab_mem[tab_addr_i] <= tab_data_i;
    end
  end

  // The index counter tracks the position in the block; the sticky flag records a lost alignment.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx_cnt    <= 6'd0;
      sync_err_o <= 1'b0;
    end else if (accept) begin
      idx_cnt <= cur_idx + 6'd1;
      if (in_first_i && (idx_cnt != 6'd0)) begin
        sync_err_o <= 1'b1;
      end
    end
  end

  // S1 registers the coefficient and its index, and reads the table synchronously.
  // A read in the same cycle as a write to that address returns the old value.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_idx   <= 6'd0;
      s1_rec   <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= in_data_i;
        s1_idx  <= cur_idx;
        s1_rec  <= tab_mem[cur_idx];
      end
    end
  end

  // Take the magnitude in IW+1 bits so that the most negative input has an exact magnitude.
  always_comb begin
    s1_ext  = {s1_data[IW-1], s1_data};
    s1_mag  = s1_ext[IW] ? (~s1_ext + 1'b1) : s1_ext;
    s1_prod = PW'(s1_mag) * PW'(s1_rec);
`ifdef QUANT_ROUND_EN
    s1_prod = s1_prod + RND_HALF;
`endif
  end

  // S2 holds the unsigned product and remembers the input sign.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s2_valid <= 1'b0;
      s2_neg   <= 1'b0;
      s2_idx   <= 6'd0;
      s2_prod  <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_neg  <= s1_ext[IW];
        s2_idx  <= s1_idx;
        s2_prod <= s1_prod;
      end
    end
  end

  // Shift, saturate the magnitude against the limit for its sign, then restore the sign.
  always_comb begin
    s2_q = QW'(s2_prod >> SHIFT);
    if (s2_neg) begin
      s2_sat = (s2_q > NEG_LIM) ? NEG_MAG : s2_q[OW-1:0];
    end else begin
      s2_sat = (s2_q > POS_LIM) ? POS_MAG : s2_q[OW-1:0];
    end
    s2_res = s2_neg ? (~s2_sat + 1'b1) : s2_sat;
  end

  // S3 is the registered output stream.
  // The block counter advances when the consumer takes index 63.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_idx_o   <= 6'd0;
      out_last_o  <= 1'b0;
      blk_cnt_o   <= 16'd0;
    end else begin
      if (!stall) begin
        out_valid_o <= s2_valid;
        if (s2_valid) begin
          out_data_o <= $signed(s2_res);
          out_idx_o  <= s2_idx;
          out_last_o <= (s2_idx == 6'd63);
        end
      end
      if (out_valid_o && out_ready_i && out_last_o) begin
        blk_cnt_o <= blk_cnt_o + 16'd1;
      end
    end
  end

endmodule
